arith_ram_sequencer: RTL and testbench
======================================

// Module: arith_ram_sequencer
// PURPOSE
//  Arithmetic-side master for port B of the shared 2^ADDR_W x DATA_W dual-port RAM; the HPS owns port A.
//  On start, reads operand vectors A[i] and B[i], computes R[i] = A[i] +/- B[i] as two's-complement, and writes R[i] back.
//  Bridges HPS-staged operands to HPS-readable results; drives addr_arith/data_arith/we_arith and consumes q_arith.
// PARAMETERS
//  DATA_W  32  RAM word width / operand width
//  ADDR_W  11  RAM address width; count is ADDR_W+1 bits wide
// PORTS
//  clock       in   1         single clock, all logic posedge
//  reset       in   1         synchronous, active-high
//  start       in   1         launch job; sampled only in IDLE
//  mode        in   1         0 = add, 1 = subtract (A-B); latched at start
//  base_a      in   ADDR_W    first address of A vector; latched at start
//  base_b      in   ADDR_W    first address of B vector; latched at start
//  base_r      in   ADDR_W    first address of result vector; latched at start
//  count       in   ADDR_W+1  element count, 0..2^ADDR_W; latched at start
//  busy        out  1         high while a job runs
//  done        out  1         one-cycle pulse at job end
//  ovf         out  1         sticky signed overflow, cleared at start
//  addr_arith  out  ADDR_W    RAM port B address, registered
//  data_arith  out  DATA_W    RAM port B write data, registered
//  we_arith    out  1         RAM port B write enable, registered
//  q_arith     in   DATA_W    RAM port B read data, 1-cycle registered latency
// BEHAVIOUR
//  Reset: state=IDLE; busy/done/ovf/we_arith=0; addr_arith/data_arith/idx/opa=0. Reset overrides every state.
//  Reset mid-job aborts the job. we_arith is 0 after that edge. RAM words already written stay as written.
//  FSM IDLE -> ADDR_A -> ADDR_B -> CALC -> WRITE -> (ADDR_A | DONE) -> IDLE. Each element takes 4 cycles.
//  IDLE & start & count!=0: latch inputs, idx<=0, addr_arith<=base_a, ovf<=0, busy<=1, state<=ADDR_A.
//  IDLE & start & count==0: latch inputs, ovf<=0, state<=DONE, no RAM access.
//  ADDR_A: RAM samples A addr. Drive addr_arith<=base_b+idx.
//  ADDR_B: RAM samples B addr. Capture opa<=q_arith (=A[i]).
//  CALC: res = mode ? opa-q_arith : opa+q_arith, DATA_W bits, wraps mod 2^DATA_W.
//    Drive data_arith<=res, addr_arith<=base_r+idx, we_arith<=1.
//    ovf<=ovf | signed overflow of the operation.
//  WRITE: RAM writes R[i]; we_arith<=0.
//    If idx==count-1, go to DONE. Else idx<=idx+1, addr_arith<=base_a+idx+1, go to ADDR_A.
//  DONE: done<=1 for exactly one cycle, busy<=0, state<=IDLE.
//  Job length: 4*count + 2 cycles from the start edge to the done pulse; count==0 gives 2 cycles.
//  Address sums wrap mod 2^ADDR_W. we_arith is high for exactly 1 cycle per element.
//  start while busy is ignored; base/count/mode changes mid-job have no effect.
//  In-place operation (base_r==base_a or base_r==base_b) is legal: element i is read before it is written.
//  Port-A collisions: HPS must not write active addresses during a job. The result of a collision is undefined.
// CONFIGURATION
//  ARITH_SAT_EN defined: on signed overflow, data_arith saturates to 2^(DATA_W-1)-1 if the true result is
//    positive, or -2^(DATA_W-1) if negative. ovf is still set.
//  ARITH_SAT_EN undefined: wrap-around result; ovf is still set. No other difference.
// TESTING
//  1 Reset mid-job: assert reset in CALC -> next cycle we_arith=0, busy=0, state IDLE; a fresh start runs normally.
//  2 Add: A[0..3]={1,2,3,4}@0, B={10,20,30,40}@16, base_r=32, count=4, mode=0
//    -> R@32={11,22,33,44}; done 18 cycles after start; ovf=0.
//  3 Sub: A=5@100, B=7@200, count=1, mode=1 -> R@300=32'hFFFFFFFE; ovf=0.
//  4 Overflow: A=32'h7FFFFFFF, B=1, add -> ovf=1.
//    With ARITH_SAT_EN, R=32'h7FFFFFFF; without it, R=32'h80000000.
//  5 Wrap and in-place: base_a=base_r=2046, base_b=0, count=4 -> addresses 2046,2047,0,1 touched;
//    R overwrites A correctly.
//  6 Edge handshakes: count=0 -> done 2 cycles after start, no we_arith.
//    start pulsed while busy -> ignored, exactly one done.

Source files
------------

// File: rtl/arith_ram_sequencer.sv
// Port-B master for the shared operand RAM: R[i] = A[i] +/- B[i], four cycles per element.
// Optional macro ARITH_SAT_EN: saturate results on signed overflow instead of wrapping.
module arith_ram_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_r,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [ADDR_W-1:0] addr_arith,
    output logic [DATA_W-1:0] data_arith,
    output logic              we_arith,
    input  logic [DATA_W-1:0] q_arith
);

    // state    | meaning
    // IDLE     | waiting for start
    // ADDR_A   | RAM samples A address; present B address
    // ADDR_B   | RAM samples B address; capture A[i]
    // CALC     | combine A[i] with B[i]; present result and write enable
    // WRITE    | RAM writes R[i]; advance or finish
    // DONE     | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_A, S_ADDR_B, S_CALC, S_WRITE, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ONE_A   = 1;
    localparam logic [ADDR_W:0]   ONE_C   = 1;
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t state, next_state;

    logic              mode_q, mode_nxt;
    logic [ADDR_W-1:0] base_a_q, base_a_nxt;
    logic [ADDR_W-1:0] base_b_q, base_b_nxt;
    logic [ADDR_W-1:0] base_r_q, base_r_nxt;
    logic [ADDR_W:0]   count_q, count_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic [DATA_W-1:0] opa, opa_nxt;
    logic              busy_nxt, done_nxt, ovf_nxt, we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] data_nxt;

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] res;
    logic              ovf_op;
    logic              last;

    assign last = ({1'b0, idx} == (count_q - ONE_C));
    assign sum  = mode_q ? (opa - q_arith) : (opa + q_arith);

    // Overflow iff the operands' effective signs agree and the result sign differs from A.
    assign ovf_op = mode_q ? ((opa[DATA_W-1] != q_arith[DATA_W-1]) && (sum[DATA_W-1] != opa[DATA_W-1]))
                           : ((opa[DATA_W-1] == q_arith[DATA_W-1]) && (sum[DATA_W-1] != opa[DATA_W-1]));

`ifdef ARITH_SAT_EN
    assign res = ovf_op ? (opa[DATA_W-1] ? SAT_MIN : SAT_MAX) : sum;
`else
    assign res = sum;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            mode_q     <= 1'b0;
            base_a_q   <= '0;
            base_b_q   <= '0;
            base_r_q   <= '0;
            count_q    <= '0;
            idx        <= '0;
            opa        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ovf        <= 1'b0;
            addr_arith <= '0;
            data_arith <= '0;
            we_arith   <= 1'b0;
        end else begin
            state      <= next_state;
            mode_q     <= mode_nxt;
            base_a_q   <= base_a_nxt;
            base_b_q   <= base_b_nxt;
            base_r_q   <= base_r_nxt;
            count_q    <= count_nxt;
            idx        <= idx_nxt;
            opa        <= opa_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            ovf        <= ovf_nxt;
            addr_arith <= addr_nxt;
            data_arith <= data_nxt;
            we_arith   <= we_nxt;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = (count == '0) ? S_DONE : S_ADDR_A;
            S_ADDR_A: next_state = S_ADDR_B;
            S_ADDR_B: next_state = S_CALC;
            S_CALC:   next_state = S_WRITE;
            S_WRITE:  next_state = last ? S_DONE : S_ADDR_A;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        mode_nxt   = mode_q;
        base_a_nxt = base_a_q;
        base_b_nxt = base_b_q;
        base_r_nxt = base_r_q;
        count_nxt  = count_q;
        idx_nxt    = idx;
        opa_nxt    = opa;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        ovf_nxt    = ovf;
        addr_nxt   = addr_arith;
        data_nxt   = data_arith;
        we_nxt     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    mode_nxt   = mode;
                    base_a_nxt = base_a;
                    base_b_nxt = base_b;
                    base_r_nxt = base_r;
                    count_nxt  = count;
                    ovf_nxt    = 1'b0;
                    if (count != '0) begin
                        idx_nxt  = '0;
                        addr_nxt = base_a;
                        busy_nxt = 1'b1;
                    end
                end
            end
            S_ADDR_A: addr_nxt = base_b_q + idx;
            S_ADDR_B: opa_nxt = q_arith;
            S_CALC: begin
                data_nxt = res;
                addr_nxt = base_r_q + idx;
                we_nxt   = 1'b1;
                ovf_nxt  = ovf | ovf_op;
            end
            S_WRITE: begin
                if (!last) begin
                    idx_nxt  = idx + ONE_A;
                    addr_nxt = base_a_q + idx + ONE_A;
                end
            end
            S_DONE: begin
                done_nxt = 1'b1;
                busy_nxt = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_arith_ram_sequencer.sv
// Directed and randomized bench for arith_ram_sequencer against a sequential reference memory model.
// Honors ARITH_SAT_EN the same way the design does.
module tb_arith_ram_sequencer;

    localparam int DW = 32;
    localparam int AW = 11;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset, start, mode;
    logic [AW-1:0] base_a, base_b, base_r;
    logic [AW:0]   count;
    logic          busy, done, ovf, we_arith;
    logic [AW-1:0] addr_arith;
    logic [DW-1:0] data_arith, q_arith;

    logic          hps_we;
    logic [AW-1:0] hps_addr;
    logic [DW-1:0] hps_data;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    int vectors = 0;
    int errors  = 0;

    arith_ram_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .base_a(base_a), .base_b(base_b), .base_r(base_r), .count(count),
        .busy(busy), .done(done), .ovf(ovf),
        .addr_arith(addr_arith), .data_arith(data_arith), .we_arith(we_arith),
        .q_arith(q_arith)
    );

    always #5 clock = ~clock;

    // Dual-port RAM: port A driven by the bench as the HPS, port B by the DUT.
    always @(posedge clock) begin
        if (hps_we)   mem[hps_addr]   <= hps_data;
        if (we_arith) mem[addr_arith] <= data_arith;
        q_arith <= mem[addr_arith];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clock);
        hps_we = 1'b1; hps_addr = a; hps_data = d;
        @(negedge clock);
        hps_we = 1'b0;
        ref_mem[a] = d;
    endtask

    function automatic logic [DW-1:0] rand_word();
        case ($urandom_range(0, 7))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Signed reference arithmetic on wide integers, clamped or wrapped.
    function automatic logic [DW-1:0] exp_res(input logic m, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b, output logic ov);
        longint sa, sb, t;
        logic [63:0] tv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        t  = m ? (sa - sb) : (sa + sb);
        ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
`ifdef ARITH_SAT_EN
        if (t > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (t < -64'sd2147483648) return 32'h8000_0000;
`endif
        tv = t;
        return tv[DW-1:0];
    endfunction

    task automatic run_job(input logic m, input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                           input logic [AW-1:0] br, input logic [AW:0] cnt,
                           input bit perturb, input string tag);
        int n, wes, extra;
        bit seen;
        logic exp_ov, ov1;
        logic [AW-1:0] ra;
        exp_ov = 1'b0;
        for (int i = 0; i < int'(cnt); i++) begin
            logic [AW-1:0] ia, ib, ir;
            ia = ba + AW'(i); ib = bb + AW'(i); ir = br + AW'(i);
            ref_mem[ir] = exp_res(m, ref_mem[ia], ref_mem[ib], ov1);
            exp_ov |= ov1;
        end
        @(negedge clock);
        mode = m; base_a = ba; base_b = bb; base_r = br; count = cnt; start = 1'b1;
        @(posedge clock);
        n = 1;
        @(negedge clock);
        start = 1'b0; wes = 0; seen = 0;
        while (n < 4 * int'(cnt) + 40) begin
            if (we_arith) wes++;
            if (done) begin seen = 1; break; end
            if (n == 2 && cnt != 0) chk({tag, ".busy"}, busy, 1);
            if (perturb && n == 3) begin
                start = 1'b1; mode = ~m;
                base_a = AW'($urandom); base_b = AW'($urandom); base_r = AW'($urandom);
                count = (AW+1)'($urandom_range(1, 20));
            end else start = 1'b0;
            @(posedge clock); n++;
            @(negedge clock);
        end
        start = 1'b0;
        chk({tag, ".done_seen"}, seen, 1);
        chk({tag, ".latency"}, n, 4 * int'(cnt) + 2);
        chk({tag, ".we_pulses"}, wes, int'(cnt));
        chk({tag, ".ovf"}, ovf, exp_ov);
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (done) extra++;
            if (we_arith) extra++;
        end
        chk({tag, ".quiet_after"}, extra, 0);
        chk({tag, ".busy_after"}, busy, 0);
        for (int i = 0; i < int'(cnt); i++) begin
            ra = br + AW'(i);
            chk({tag, ".R"}, mem[ra], ref_mem[ra]);
        end
    endtask

    initial begin
        logic [AW-1:0] ba, bb, br;
        logic [AW:0]   cnt;
        reset = 1'b1; start = 1'b0; mode = 1'b0;
        base_a = '0; base_b = '0; base_r = '0; count = '0;
        hps_we = 1'b0; hps_addr = '0; hps_data = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.ovf", ovf, 0);
        chk("rst.we", we_arith, 0);
        chk("rst.addr", addr_arith, 0);
        chk("rst.data", data_arith, 0);
        reset = 1'b0;

        // Add: four elements
        for (int i = 0; i < 4; i++) begin
            poke(AW'(i), DW'(i + 1));
            poke(AW'(16 + i), DW'(10 * (i + 1)));
            poke(AW'(32 + i), 32'hDEAD_BEEF);
        end
        run_job(1'b0, 11'd0, 11'd16, 11'd32, 12'd4, 1'b0, "add");
        chk("add.R3", mem[35], 32'd44);

        // Subtract: negative result
        poke(11'd100, 32'd5);
        poke(11'd200, 32'd7);
        run_job(1'b1, 11'd100, 11'd200, 11'd300, 12'd1, 1'b0, "sub");
        chk("sub.R0", mem[300], 32'hFFFF_FFFE);

        // Signed overflow on add
        poke(11'd400, 32'h7FFF_FFFF);
        poke(11'd401, 32'd1);
        run_job(1'b0, 11'd400, 11'd401, 11'd402, 12'd1, 1'b0, "ovf");
`ifdef ARITH_SAT_EN
        chk("ovf.R0", mem[402], 32'h7FFF_FFFF);
`else
        chk("ovf.R0", mem[402], 32'h8000_0000);
`endif

        // Address wrap with in-place result over A
        for (int i = 0; i < 4; i++) begin
            poke(AW'(2046 + i), rand_word());
            poke(AW'(i), rand_word());
        end
        run_job(1'b0, 11'd2046, 11'd0, 11'd2046, 12'd4, 1'b0, "wrap");

        // Zero-length job
        run_job(1'b0, 11'd500, 11'd600, 11'd700, 12'd0, 1'b0, "zero");

        // Start and input changes while busy are ignored
        for (int i = 0; i < 3; i++) begin
            poke(AW'(800 + i), rand_word());
            poke(AW'(900 + i), rand_word());
        end
        run_job(1'b1, 11'd800, 11'd900, 11'd1000, 12'd3, 1'b1, "busy_start");

        // Reset while in CALC aborts the job without writing
        poke(11'd1100, 32'd3);
        poke(11'd1101, 32'd4);
        poke(11'd1102, 32'h1234_5678);
        @(negedge clock);
        mode = 1'b0; base_a = 11'd1100; base_b = 11'd1101; base_r = 11'd1102; count = 12'd1; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst.we", we_arith, 0);
        chk("midrst.busy", busy, 0);
        chk("midrst.done", done, 0);
        chk("midrst.addr", addr_arith, 0);
        repeat (3) @(negedge clock);
        chk("midrst.nowrite", mem[1102], 32'h1234_5678);
        run_job(1'b0, 11'd1100, 11'd1101, 11'd1102, 12'd1, 1'b0, "after_rst");
        chk("after_rst.R0", mem[1102], 32'd7);

        // Randomized jobs
        for (int k = 0; k < 12; k++) begin
            ba  = AW'($urandom);
            bb  = AW'($urandom);
            br  = AW'($urandom);
            cnt = (AW+1)'($urandom_range(1, 8));
            for (int i = 0; i < int'(cnt); i++) begin
                poke(ba + AW'(i), rand_word());
                poke(bb + AW'(i), rand_word());
            end
            run_job(1'($urandom_range(0, 1)), ba, bb, br, cnt, bit'($urandom_range(0, 1)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
